// File: rtl/types_pkg.sv
// Shared types and constants for the one-word-per-line direct-mapped data cache.
package types_pkg;

  localparam int DATA_BUS   = 32;
  localparam int CACHE_SETS = 8;

  // Controller states: idle/lookup, line fill from RAM, write-through to RAM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state;

  // Word-aligned form of a byte address (byte offset forced to zero)
  function automatic logic [DATA_BUS-1:0] wordAlign(input logic [DATA_BUS-1:0] a);
    return a & ~(DATA_BUS'(3));
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and RAM-side signals of the data cache, bundled as one interface.
// The slave modport is the cache's view; master is the view of the CPU plus
// backing RAM that surround it.
interface data_cache_if;
  import types_pkg::*;

  logic                req;
  logic                WE;
  logic [DATA_BUS-1:0] A;
  logic [DATA_BUS-1:0] WD;
  logic                flush;
  logic [DATA_BUS-1:0] RD;
  logic                stall;

  logic                mem_req;
  logic                mem_we;
  logic [DATA_BUS-1:0] mem_addr;
  logic [DATA_BUS-1:0] mem_wdata;
  logic [DATA_BUS-1:0] mem_rdata;
  logic                mem_ready;

  modport master (
    output req, WE, A, WD, flush, mem_rdata, mem_ready,
    input  RD, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, WE, A, WD, flush, mem_rdata, mem_ready,
    output RD, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_cache_array.sv
// Line storage for the data cache: per-line valid bit, tag and data word.
// Asynchronous read, synchronous write, single-cycle clear of all valid bits.
// Tag and data words are never reset; only the valid bits carry meaning after
// a clear.
module cache_array #(
  parameter  int SETS   = 8,
  parameter  int TAG_W  = 27,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  wTag,
  input  logic [DATA_W-1:0] wData,
  output logic              rValid,
  output logic [TAG_W-1:0]  rTag,
  output logic [DATA_W-1:0] rData
);

  logic [SETS-1:0]   validBits;
  logic [TAG_W-1:0]  tagMem  [SETS];
  logic [DATA_W-1:0] dataMem [SETS];

  // Valid bits: clear-all has priority over a line write
  always_ff @(posedge clk) begin
    if (clear) begin
      validBits <= '0;
    end else if (we) begin
      validBits[idx] <= 1'b1;
    end
  end

  // Tag and data words: written on a line write, never reset
  always_ff @(posedge clk) begin
    if (we) begin
      tagMem[idx]  <= wTag;
      dataMem[idx] <= wData;
    end
  end

  assign rValid = validBits[idx];
  assign rTag   = tagMem[idx];
  assign rData  = dataMem[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit
// word per line. Read hits complete combinationally in IDLE; misses fill the
// line from RAM and the held access is retried. Writes always go through to
// RAM; the line is refreshed only when the write hits.
module data_cache
  import types_pkg::*;
#(
  parameter int SETS = CACHE_SETS
) (
  input  logic                clk,
  input  logic                rst,
  data_cache_if.slave         bus,
  output logic [DATA_BUS-1:0] hit_count,
  output logic [DATA_BUS-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_BUS - 2 - IDX_W;

  cache_state          state;
  cache_state          nextState;
  // Set once RAM has serviced the held access, so its retry neither re-issues
  // a write nor counts as a fresh hit; cleared when the CPU is released.
  logic                done;

  logic [IDX_W-1:0]    lineIdx;
  logic [TAG_W-1:0]    lineTag;
  logic                lineValid;
  logic [TAG_W-1:0]    storedTag;
  logic [DATA_BUS-1:0] storedData;
  logic                hit;

  logic                readHit;
  logic                missEvt;
  logic                stallInt;
  logic                memReq;
  logic                memWe;
  logic                arrWe;
  logic                clearReq;
  logic                serviced;

  logic                arrClear;
  logic                arrWrEn;
  logic [DATA_BUS-1:0] arrWData;

  assign lineIdx = bus.A[2 +: IDX_W];
  assign lineTag = bus.A[DATA_BUS-1 -: TAG_W];
  assign hit     = lineValid && (storedTag == lineTag);

  // Reset wipes the valid bits and suppresses any pending line update
  assign arrClear = rst | clearReq;
  assign arrWrEn  = arrWe & ~rst;
  assign arrWData = (state == FILL) ? bus.mem_rdata : bus.WD;

  cache_array #(
    .SETS   (SETS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_BUS)
  ) uArray (
    .clk    (clk),
    .clear  (arrClear),
    .we     (arrWrEn),
    .idx    (lineIdx),
    .wTag   (lineTag),
    .wData  (arrWData),
    .rValid (lineValid),
    .rTag   (storedTag),
    .rData  (storedData)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    nextState = state;
    stallInt  = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    readHit   = 1'b0;
    missEvt   = 1'b0;
    arrWe     = 1'b0;
    clearReq  = 1'b0;
    serviced  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.flush) begin
          // Flush takes the cycle; a simultaneous access waits one cycle
          clearReq = 1'b1;
          stallInt = bus.req;
        end else if (bus.req && !bus.WE) begin
          if (hit) begin
            readHit = 1'b1;
          end else begin
            stallInt  = 1'b1;
            missEvt   = 1'b1;
            nextState = FILL;
          end
        end else if (bus.req && bus.WE) begin
          if (!done) begin
            stallInt  = 1'b1;
            nextState = WRITE;
          end
        end
      end
      FILL: begin
        memReq   = 1'b1;
        stallInt = 1'b1;
        if (bus.mem_ready) begin
          arrWe     = 1'b1;
          serviced  = 1'b1;
          nextState = IDLE;
        end
      end
      WRITE: begin
        memReq   = 1'b1;
        memWe    = 1'b1;
        stallInt = 1'b1;
        if (bus.mem_ready) begin
          arrWe     = hit;
          serviced  = 1'b1;
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Serviced-access flag
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else if (serviced) begin
      done <= 1'b1;
    end else if (!stallInt) begin
      done <= 1'b0;
    end
  end

  // Access statistics; the retry that follows a fill is not a new hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (readHit && !done) begin
        hit_count <= hit_count + 1'b1;
      end
      if (missEvt) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end

  assign bus.stall     = stallInt & ~rst;
  assign bus.RD        = readHit ? storedData : '0;
  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = wordAlign(bus.A);
  assign bus.mem_wdata = bus.WD;

endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache: directed scenarios followed by randomized CPU
// accesses, checked against a transaction-level model of the cache contents,
// RAM contents, stall latency and statistics counters.
module tb_data_cache;
  import types_pkg::*;

  localparam int SETS  = 8;
  localparam int IDX_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_cache_if bus();

  data_cache #(.SETS(SETS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  logic [31:0] ram [int unsigned];
  bit          refValid [SETS];
  logic [31:0] refTag   [SETS];
  logic [31:0] refData  [SETS];
  logic [31:0] refHits;
  logic [31:0] refMisses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ramRead(input logic [31:0] a);
    int unsigned key;
    key = a >> 2;
    if (!ram.exists(key)) ram[key] = $urandom;
    return ram[key];
  endfunction

  task automatic modelReset();
    foreach (refValid[i]) refValid[i] = 1'b0;
    refHits   = 0;
    refMisses = 0;
  endtask

  task automatic modelFlush();
    foreach (refValid[i]) refValid[i] = 1'b0;
  endtask

  // One CPU access held until stall drops, with a RAM that answers after
  // waitN wait cycles. Expectations come from the model state beforehand.
  task automatic cpuAccess(input bit isWr, input logic [31:0] addr, input logic [31:0] wd,
                           input bit fl, input int waitN, input string nm);
    int unsigned idx;
    logic [31:0] tg;
    bit          expHit;
    int          expStall;
    int          stallCnt;
    int          pulses;
    int          reqCyc;
    bit          finished;
    logic [31:0] gotRd;
    logic [31:0] expRd;

    idx = (addr >> 2) % SETS;
    tg  = addr >> (2 + IDX_W);
    if (fl) modelFlush();
    expHit   = refValid[idx] && (refTag[idx] == tg);
    expStall = fl ? 1 : 0;
    if (isWr || !expHit) expStall += 2 + waitN;

    bus.req   = 1'b1;
    bus.WE    = isWr;
    bus.A     = addr;
    bus.WD    = wd;
    bus.flush = fl;
    stallCnt  = 0;
    pulses    = 0;
    reqCyc    = 0;
    finished  = 1'b0;
    gotRd     = '0;

    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      if (cyc > 0) bus.flush = 1'b0;
      bus.mem_ready = bus.mem_req && (reqCyc == waitN);
      bus.mem_rdata = bus.mem_ready ? ramRead(bus.mem_addr) : $urandom;
      #1;
      if (!bus.stall) begin
        finished = 1'b1;
        gotRd    = bus.RD;
      end else begin
        stallCnt++;
        chk({nm, "/rdWhileStalled"}, bus.RD, 32'h0);
        if (bus.mem_req && bus.mem_ready) begin
          chk({nm, "/memAddr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
          chk({nm, "/memWe"}, {31'b0, bus.mem_we}, {31'b0, isWr});
          if (bus.mem_we) begin
            pulses++;
            chk({nm, "/memWdata"}, bus.mem_wdata, wd);
            ram[bus.mem_addr >> 2] = bus.mem_wdata;
          end
          reqCyc = 0;
        end else if (bus.mem_req) begin
          reqCyc++;
        end
        @(posedge clk);
        #1;
      end
    end

    if (!finished) chk({nm, "/timeout"}, 32'd1, 32'd0);
    chk({nm, "/stallCycles"}, stallCnt, expStall);
    chk({nm, "/wePulses"}, pulses, isWr ? 1 : 0);

    if (isWr) begin
      if (expHit) refData[idx] = wd;
      expRd = '0;
    end else begin
      if (expHit) begin
        refHits = refHits + 1;
      end else begin
        refMisses     = refMisses + 1;
        refValid[idx] = 1'b1;
        refTag[idx]   = tg;
        refData[idx]  = ramRead(addr);
      end
      expRd = refData[idx];
    end
    chk({nm, "/rd"}, gotRd, expRd);

    // Completing edge with the access still presented
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req   = 1'b0;
    bus.WE    = 1'b0;
    bus.flush = 1'b0;
    chk({nm, "/hitCount"}, hit_count, refHits);
    chk({nm, "/missCount"}, miss_count, refMisses);
  endtask

  task automatic idleCycle(input bit fl);
    bus.req       = 1'b0;
    bus.flush     = fl;
    bus.mem_ready = 1'b0;
    #1;
    chk("idle/stall", {31'b0, bus.stall}, 32'd0);
    chk("idle/memReq", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    if (fl) modelFlush();
  endtask

  initial begin
    bit          isWr;
    bit          fl;
    logic [31:0] addr;

    rst           = 1'b1;
    bus.req       = 1'b1;
    bus.WE        = 1'b0;
    bus.A         = 32'h40;
    bus.WD        = '0;
    bus.flush     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset with a request presented
    @(posedge clk);
    #1;
    chk("reset/stall", {31'b0, bus.stall}, 32'd0);
    chk("reset/memReq", {31'b0, bus.mem_req}, 32'd0);
    chk("reset/hitCount", hit_count, 32'd0);
    chk("reset/missCount", miss_count, 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.req = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    // Directed scenarios
    ram[32'h40 >> 2] = 32'hDEAD_BEEF;
    cpuAccess(1'b0, 32'h40, 32'h0,         1'b0, 2, "missFill");
    cpuAccess(1'b0, 32'h40, 32'h0,         1'b0, 0, "readHit");
    cpuAccess(1'b1, 32'h40, 32'h1234_5678, 1'b0, 1, "writeHit");
    cpuAccess(1'b0, 32'h40, 32'h0,         1'b0, 0, "readAfterWrite");
    cpuAccess(1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, 0, "writeMissNoAlloc");
    chk("writeMissNoAlloc/ram", ram[32'h80 >> 2], 32'hCAFE_F00D);
    cpuAccess(1'b0, 32'h40, 32'h0,         1'b0, 0, "readAfterWriteMiss");
    cpuAccess(1'b0, 32'h40, 32'h0,         1'b1, 1, "flushWithRead");

    // Reset while a fill is outstanding
    bus.req       = 1'b1;
    bus.WE        = 1'b0;
    bus.A         = 32'h100;
    bus.mem_ready = 1'b0;
    #1;
    chk("abort/missStall", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("abort/fillReq", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort/memReqAfterRst", {31'b0, bus.mem_req}, 32'd0);
    chk("abort/stallInRst", {31'b0, bus.stall}, 32'd0);
    rst     = 1'b0;
    bus.req = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    cpuAccess(1'b0, 32'h100, 32'h0, 1'b0, 1, "abort/retryMisses");

    // Randomized traffic over a small address pool to force hits and conflicts
    for (int n = 0; n < 300; n++) begin
      isWr = ($urandom_range(0, 9) < 3);
      fl   = ($urandom_range(0, 9) == 0);
      addr = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      cpuAccess(isWr, addr, $urandom, fl, $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 3) == 0) idleCycle($urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
